// File: rtl/float_pkg.sv
// Shared single-precision float constants and field layout for the float blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package float_pkg;

  localparam int FLOAT_EXP_W = 8;
  localparam int FLOAT_MAN_W = 23;
  localparam int FLOAT_W     = 1 + FLOAT_EXP_W + FLOAT_MAN_W;

  localparam logic [FLOAT_EXP_W-1:0] FLOAT_BIAS = 8'd127;
  localparam logic [FLOAT_W-1:0]     FLOAT_ZERO = 32'h0000_0000;

  // IEEE-754 single-precision field layout, MSB first.
  typedef struct packed {
    logic                   sign;
    logic [FLOAT_EXP_W-1:0] exp;
    logic [FLOAT_MAN_W-1:0] man;
  } float_t;

endpackage

// File: rtl/int_to_float_if.sv
// Strobe/ack operand and result channels of the integer-to-float converter.
// Latency: n/a (wiring only).
// Backpressure: i_A held by producer until o_A_ACK; o_Z held by converter until i_Z_ACK.
interface int_to_float_if #(
  parameter int IN_W = 24
);
  import float_pkg::*;

  logic [IN_W-1:0]    i_A;
  logic               i_A_STB;
  logic               o_A_ACK;
  logic [FLOAT_W-1:0] o_Z;
  logic               o_Z_STB;
  logic               i_Z_ACK;

  // Converter side.
  modport slave (
    input  i_A, i_A_STB, i_Z_ACK,
    output o_A_ACK, o_Z, o_Z_STB
  );

  // Producer/consumer side.
  modport master (
    output i_A, i_A_STB, i_Z_ACK,
    input  o_A_ACK, o_Z, o_Z_STB
  );

endinterface

// File: rtl/int_to_float.sv
// Converts a signed IN_W-bit integer to IEEE-754 single precision, round-to-nearest-even.
// Latency: 5 + leading zeros of the 32-bit magnitude edges from accept to o_Z_STB; 2 for zero.
// Backpressure: one sample in flight; o_Z held stable until i_Z_ACK, no new sample accepted meanwhile.
module int_to_float
  import float_pkg::*;
#(
  parameter int IN_W = 24
) (
  input logic            i_CLK,
  input logic            i_RSTN,
  int_to_float_if.slave  bus
);

  // State encodings are private to this block.
  localparam logic [3:0] S_GET_A     = 4'd0;
  localparam logic [3:0] S_UNPACK    = 4'd1;
  localparam logic [3:0] S_NORMALISE = 4'd2;
  localparam logic [3:0] S_ROUND     = 4'd3;
  localparam logic [3:0] S_PACK      = 4'd4;
  localparam logic [3:0] S_PUT_Z     = 4'd5;

  typedef enum logic [3:0] {
    GET_A     = S_GET_A,
    UNPACK    = S_UNPACK,
    NORMALISE = S_NORMALISE,
    ROUND     = S_ROUND,
    PACK      = S_PACK,
    PUT_Z     = S_PUT_Z
  } state_t;

  state_t            state;
  logic [IN_W-1:0]   a_q;     // captured sample
  logic              sign_q;  // result sign
  logic [31:0]       m_q;     // magnitude, left-justified during normalise
  logic [7:0]        e_q;     // unbiased exponent
  logic [22:0]       man_q;   // rounded fraction (hidden bit dropped)
  float_t            z_q;     // packed result awaiting output

  logic signed [31:0] a_sx;
  logic [31:0]        a_abs;
  logic               rnd_up;
  logic               man_carry;

  // Sign-extend to 32 bits and take the magnitude; -2^31 wraps to 32'h8000_0000, which is the correct unsigned magnitude.
  always_comb begin
    a_sx      = 32'(signed'(a_q));
    a_abs     = a_sx[31] ? (~a_sx + 32'd1) : a_sx;
    // Guard = m[7], round = m[6], sticky = m[5:0]; m[8] breaks ties to even.
    rnd_up    = m_q[7] & (m_q[6] | (|m_q[5:0]) | m_q[8]);
    man_carry = rnd_up & (&m_q[30:8]);
  end

  // Conversion FSM: every output and datapath register changes only here.
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state       <= GET_A;
      a_q         <= '0;
      sign_q      <= 1'b0;
      m_q         <= '0;
      e_q         <= '0;
      man_q       <= '0;
      z_q         <= FLOAT_ZERO;
      bus.o_A_ACK <= 1'b0;
      bus.o_Z_STB <= 1'b0;
      bus.o_Z     <= FLOAT_ZERO;
    end else begin
      case (state)
        GET_A: begin
          // Ack is raised one edge after entry, giving one idle cycle between results.
          if (bus.o_A_ACK && bus.i_A_STB) begin
            a_q         <= bus.i_A;
            bus.o_A_ACK <= 1'b0;
            state       <= UNPACK;
          end else begin
            bus.o_A_ACK <= 1'b1;
          end
        end

        UNPACK: begin
          sign_q <= a_sx[31];
          m_q    <= a_abs;
          e_q    <= 8'd31;
          if (a_abs == 32'd0) begin
            z_q   <= FLOAT_ZERO;
            state <= PUT_Z;
          end else begin
            state <= NORMALISE;
          end
        end

        NORMALISE: begin
          // One bit per cycle until the leading one reaches bit 31.
          if (!m_q[31]) begin
            m_q <= {m_q[30:0], 1'b0};
            e_q <= e_q - 8'd1;
          end else begin
            state <= ROUND;
          end
        end

        ROUND: begin
          // An all-ones mantissa rounding up becomes 1.0 at the next exponent.
          if (man_carry) begin
            man_q <= '0;
            e_q   <= e_q + 8'd1;
          end else begin
            man_q <= m_q[30:8] + 23'(rnd_up);
          end
          state <= PACK;
        end

        PACK: begin
          // Exponent stays within 0..32 unbiased, so no overflow/denormal handling exists.
          z_q   <= {sign_q, 8'(e_q + FLOAT_BIAS), man_q};
          state <= PUT_Z;
        end

        PUT_Z: begin
          if (!bus.o_Z_STB) begin
            bus.o_Z_STB <= 1'b1;
            bus.o_Z     <= z_q;
          end else if (bus.i_Z_ACK) begin
            bus.o_Z_STB <= 1'b0;
            state       <= GET_A;
          end
        end

        default: begin
          bus.o_A_ACK <= 1'b0;
          bus.o_Z_STB <= 1'b0;
          state       <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: doc/int_to_float.md
INT_TO_FLOAT -- requirements
Module: int_to_float

Interface
REQ-001 SHALL have parameter IN_W, default 24, signed two's-complement input width, legal range 2..32.
REQ-002 SHALL have port i_CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_RSTN  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port i_A  input  IN_W  signed integer sample (ADS1292 channel data at default width).
REQ-005 SHALL have port i_A_STB  input  1  i_A valid.
REQ-006 SHALL have port o_A_ACK  output  1  block ready to accept i_A.
REQ-007 SHALL have port o_Z  output  32  IEEE-754 single-precision result, feeds float_multiplier/float_adder operand inputs.
REQ-008 SHALL have port o_Z_STB  output  1  o_Z valid.
REQ-009 SHALL have port i_Z_ACK  input  1  downstream has taken o_Z.

Function
REQ-010 SHALL be an FSM with states GET_A, UNPACK, NORMALISE, ROUND, PACK, PUT_Z; all outputs registered.
REQ-011 GET_A: SHALL drive o_A_ACK=1; on an edge with o_A_ACK && i_A_STB, SHALL capture i_A, drive o_A_ACK=0, go to UNPACK.
REQ-012 UNPACK: sign = i_A MSB; 32-bit magnitude m = |i_A| zero-extended; exponent e = 31; if m==0, z=32'h00000000, go to PUT_Z; else go to NORMALISE.
REQ-013 |-2^(IN_W-1)| SHALL be computed without overflow (2^(IN_W-1) in the 32-bit magnitude).
REQ-014 NORMALISE: if m[31]==0, m<<=1, e-=1, stay; else go to ROUND; one bit per cycle.
REQ-015 ROUND: mantissa m[31:8], guard m[7], round m[6], sticky |m[5:0]; round to nearest even (increment if guard && (round|sticky|m[8])); on mantissa carry-out (24'hFFFFFF+1), e+=1, mantissa=24'h800000.
REQ-016 PACK: z = {sign, e+127 (8 bits), mantissa[22:0]}; no overflow, NaN, inf or denormal case exists for IN_W<=32.
REQ-017 PUT_Z: SHALL drive o_Z_STB=1 and o_Z=z; on an edge with o_Z_STB && i_Z_ACK, drive o_Z_STB=0 and go to GET_A.
REQ-018 o_Z SHALL hold stable while o_Z_STB=1 and i_Z_ACK=0 (unbounded backpressure).
REQ-019 i_A_STB outside GET_A SHALL be ignored; o_A_ACK SHALL be 0 in every other state.
REQ-020 Latency, accept edge to first edge with o_Z_STB=1: 5+lz edges, lz = leading zeros of the 32-bit magnitude; zero input: 2 edges.
REQ-021 After the output handshake edge, o_A_ACK SHALL be 1 on the following edge (one idle cycle between results).
REQ-022 For IN_W<=24, conversion SHALL be exact (no rounding occurs).

Reset
REQ-023 While i_RSTN=0, asynchronously: state=GET_A, o_A_ACK=0, o_Z_STB=0, o_Z=32'h0, internal datapath registers=0.
REQ-024 o_A_ACK SHALL first rise on the first i_CLK edge after i_RSTN deasserts.
REQ-025 Reset mid-conversion SHALL discard the sample in flight; no o_Z_STB pulse for it.

Structure
REQ-026 Shared package/header float_pkg SHALL hold FLOAT_BIAS (127), FLOAT_EXP_W (8), FLOAT_MAN_W (23), FLOAT_ZERO (32'h0); all float blocks use it.
REQ-027 State encodings SHALL be local to the module (4-bit localparams).
REQ-028 No sub-module; single clocked process; IN_W-to-32 sign extension and abs are the only combinational helpers.

Verification
REQ-029 IN_W=24: i_A=24'h000001 -> o_Z=32'h3F800000 at 36 edges; i_A=24'hFFFFFF -> 32'hBF800000.
REQ-030 IN_W=24: 24'h800000 -> 32'hCB000000; 24'h7FFFFF -> 32'h4AFFFFFE; 24'h000000 -> 32'h00000000 at 2 edges.
REQ-031 IN_W=32: 32'h7FFFFFFF -> 32'h4F000000 (carry); 32'h01000001 -> 32'h4B800000 (tie to even); 32'h01000003 -> 32'h4B800002.
REQ-032 Backpressure: i_Z_ACK low 10 cycles in PUT_Z -> o_Z, o_Z_STB stable, o_A_ACK=0, i_A_STB pulses ignored.
REQ-033 i_RSTN pulsed low during NORMALISE -> outputs 0 immediately, no stale o_Z_STB, next sample converts correctly.
REQ-034 Back-to-back random 24-bit stream with random i_Z_ACK delay -> every o_Z matches a reference int-to-float model, in order, none lost or duplicated.
